fp32_multiplier: RTL and testbench
==================================

# fp32_multiplier

Single-precision IEEE-754 floating-point multiplier with a simple pulse handshake. An operand pair is captured on a one-cycle `ready_in` strobe and processed by an iterative multi-cycle datapath. The block returns the correctly rounded product with a one-cycle `ready_out` strobe. It is a self-contained arithmetic unit that sits behind a request/response pair in the datapath and holds at most one operation at a time.

## Interface
Parameters: none.
- `clock`  in  1  single system clock; all state updates on rising edge.
- `reset_n`  in  1  reset is synchronous and active-low.
- `a`  in  32  operand A, IEEE-754 binary32; sampled when `ready_in` is accepted.
- `b`  in  32  operand B, IEEE-754 binary32; sampled with `a`.
- `ready_in`  in  1  start strobe; one cycle wide.
- `out`  out  32  product A×B, binary32; registered.
- `ready_out`  out  1  result strobe; high for exactly one cycle when `out` is updated.

## Operation
- FSM states, in order: IDLE, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, DONE.
  - IDLE: accepts the operation on `ready_in`=1 and registers `a` and `b`.
  - UNPACK: splits each operand into sign, 8-bit exponent and 24-bit significand, with the hidden bit set for normal operands. Subnormal operands use exponent −126 and hidden bit 0.
  - SPECIAL: resolves special cases directly to PACK/DONE. Checks are applied in priority order:
    1. Either operand NaN → 0x7FC00000.
    2. Inf × zero → 0x7FC00000.
    3. Inf × anything else → signed infinity, sign = sa^sb.
    4. Zero × finite → signed zero, sign = sa^sb.
  - MULTIPLY: computes a 48-bit significand product. The exponent is ea+eb (unbiased, signed, at least 10 bits wide). Result sign = sa^sb.
  - NORMALISE: shifts one bit per cycle.
    - Left-shift until the product MSB is 1 or the exponent reaches −126.
    - Right-shift with sticky accumulation while the exponent is below −126.
    - A product with its top bit set is right-aligned in a single step (exponent +1).
  - ROUND: round-to-nearest, ties-to-even, using guard, round and sticky bits from the discarded product bits. A mantissa carry-out increments the exponent.
  - PACK:
    - Exponent > 127 → signed infinity (0x7F800000 or 0xFF800000).
    - Exponent −126 with hidden bit 0 → subnormal or zero encoding.
  - DONE: drives `out`, pulses `ready_out`, then returns to IDLE.
- Full subnormal support on both inputs and outputs; no flush-to-zero.
- Only one operation is in flight. `ready_in` is ignored in every state except IDLE.
- `out` holds its last value until the next DONE.

## Timing
- Reset (`reset_n`=0 at a rising edge):
  - `out` = 0x00000000, `ready_out` = 0, FSM → IDLE.
  - Reset mid-operation aborts the operation: no `ready_out`, and `out` is cleared.
- Acceptance: `ready_in`=1 at a rising edge while in IDLE. `a` and `b` are captured at that edge; later changes to `a` and `b` have no effect.
- Latency is variable. `ready_out` rises no earlier than 5 cycles and no later than 60 cycles after the accepting edge. Special cases take the short path.
- Outputs:
  - `ready_out` is registered and high for exactly one cycle.
  - `out` is valid in that cycle and stays stable afterwards.
- The cycle after `ready_out` is IDLE. `ready_in` asserted in that cycle is accepted.
- `ready_in` asserted in the same cycle as `ready_out` is ignored.
- `ready_in` held high for several cycles in IDLE starts exactly one operation. Further pulses are ignored until DONE.

## Test plan
- Reset, then hold `ready_in`=0 for 10 cycles → `out`=0x00000000, `ready_out` never asserted.
- a=0x3F9D70A4 (1.23), b=0x4091EB85 (4.56), one-cycle `ready_in` → single `ready_out` pulse within 60 cycles, `out`=0x40B37B4A (5.6088).
- Back-to-back operations, each starting one cycle after the previous `ready_out`:
  - a=0x44F6AF68, b=0x4610099B → `out`=0x4B8ACBEC.
  - then a=0x473FF936, b=0xC6DDE29C → `out`=0xCEA66413 (negative sign).
- Special cases:
  - 0x7F800000 × 0x00000000 → 0x7FC00000.
  - 0xFF800000 × 0x40000000 → 0xFF800000.
  - 0x80000000 × 0x3F800000 → 0x80000000.
  - 0x7FC00001 × 0x3F800000 → 0x7FC00000.
- Range limits:
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000 (overflow).
  - 0x00800000 × 0x3F000000 → 0x00400000 (subnormal result).
  - 0x00000001 × 0x3F000000 → 0x00000000 (tie rounds to even zero).
- Robustness:
  - Pulse `ready_in` again while busy with different operands → ignored, first result returned.
  - Assert `reset_n`=0 mid-operation → no `ready_out`, `out`=0.

Source files
------------

// File: rtl/fp32_multiplier.sv
// fp32_multiplier
// Iterative IEEE-754 binary32 multiplier with round-to-nearest-even and full
// subnormal support. One operation is held at a time.
//
// Handshake: an operation is accepted on a rising edge where ready_in=1 and
// the unit is IDLE; a and b are captured at that edge. The result appears on
// out together with a one-cycle ready_out pulse. ready_in is ignored while an
// operation is in flight, including the ready_out cycle. out holds its value
// until the next result.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset_n   in   synchronous active-low reset (aborts any operation)
//   a, b      in   binary32 operands
//   ready_in  in   start strobe
//   out       out  registered binary32 product
//   ready_out out  registered one-cycle result strobe
module fp32_multiplier (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ready_in,
  output logic [31:0] out,
  output logic        ready_out
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, DONE
  } state_t;

  localparam logic signed [11:0] EMIN = -12'sd126;
  localparam logic signed [11:0] EMAX = 12'sd127;

  state_t             state_q;
  logic [31:0]        a_q, b_q;
  logic signed [9:0]  ea_q, eb_q;
  logic [23:0]        ma_q, mb_q;
  logic               special_q;
  logic [31:0]        spec_res_q;
  logic signed [11:0] exp_q;
  logic [47:0]        prod_q;
  logic               sticky_q;
  logic [23:0]        mant_q;
  logic [31:0]        out_q;
  logic               ready_out_q;

  // Operand classification, taken from the captured operands.
  logic       sign_d;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign sign_d = a_q[31] ^ b_q[31];
  assign a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero = (a_q[30:0] == 31'd0);
  assign b_zero = (b_q[30:0] == 31'd0);

  // Unpack: subnormals use exponent -126 with a clear hidden bit.
  logic signed [9:0] ea_d, eb_d;
  logic [23:0]       ma_d, mb_d;
  assign ea_d = (a_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, a_q[30:23]}) - 10'sd127;
  assign eb_d = (b_q[30:23] == 8'd0) ? -10'sd126 : $signed({2'b00, b_q[30:23]}) - 10'sd127;
  assign ma_d = {a_q[30:23] != 8'd0, a_q[22:0]};
  assign mb_d = {b_q[30:23] != 8'd0, b_q[22:0]};

  // Special-case resolution in priority order.
  logic        special_d;
  logic [31:0] spec_res_d;
  always_comb begin
    special_d  = 1'b1;
    spec_res_d = 32'h7FC0_0000;
    if (a_nan || b_nan) begin
      spec_res_d = 32'h7FC0_0000;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res_d = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      spec_res_d = {sign_d, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      spec_res_d = {sign_d, 31'd0};
    end else begin
      special_d = 1'b0;
    end
  end

  // Product layout: bit 46 is the units position (46 fraction bits), so a
  // normalised product has bit 46 set and bit 47 clear. Bits 22..0 are the
  // discarded bits used for rounding.
  logic [23:0] mant_hi;
  logic        guard_bit, round_bit, sticky_all, round_up;
  logic [24:0] mant_sum_d;
  assign mant_hi    = prod_q[46:23];
  assign guard_bit  = prod_q[22];
  assign round_bit  = prod_q[21];
  assign sticky_all = (|prod_q[20:0]) | sticky_q;
  assign round_up   = guard_bit & (round_bit | sticky_all | mant_hi[0]);
  assign mant_sum_d = {1'b0, mant_hi} + {24'd0, round_up};

  // Final encoding. mant_q[23]=0 only happens at exponent -126 (subnormal/zero).
  logic [31:0] pack_d;
  always_comb begin
    pack_d = {sign_d, 8'(exp_q + EMAX), mant_q[22:0]};
    if (special_q) begin
      pack_d = spec_res_q;
    end else if (exp_q > EMAX) begin
      pack_d = {sign_d, 8'hFF, 23'd0};
    end else if (!mant_q[23]) begin
      pack_d = {sign_d, 8'd0, mant_q[22:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      ma_q        <= '0;
      mb_q        <= '0;
      special_q   <= 1'b0;
      spec_res_q  <= '0;
      exp_q       <= '0;
      prod_q      <= '0;
      sticky_q    <= 1'b0;
      mant_q      <= '0;
      out_q       <= '0;
      ready_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ready_in) begin
            a_q     <= a;
            b_q     <= b;
            state_q <= UNPACK;
          end
        end
        UNPACK: begin
          ea_q    <= ea_d;
          eb_q    <= eb_d;
          ma_q    <= ma_d;
          mb_q    <= mb_d;
          state_q <= SPECIAL;
        end
        SPECIAL: begin
          special_q  <= special_d;
          spec_res_q <= spec_res_d;
          state_q    <= MULTIPLY;
        end
        MULTIPLY: begin
          prod_q   <= 48'(ma_q) * 48'(mb_q);
          exp_q    <= $signed({{2{ea_q[9]}}, ea_q}) + $signed({{2{eb_q[9]}}, eb_q});
          sticky_q <= 1'b0;
          // Special results skip normalisation but still pass ROUND and PACK,
          // which keeps the short path at the minimum latency.
          state_q  <= special_q ? ROUND : NORMALISE;
        end
        NORMALISE: begin
          if (exp_q < EMIN && prod_q == 48'd0) begin
            // Everything already shifted into sticky: further shifts cannot
            // change the result, so jump straight to the subnormal exponent.
            exp_q <= EMIN;
          end else if (prod_q[47] || exp_q < EMIN) begin
            prod_q   <= prod_q >> 1;
            sticky_q <= sticky_q | prod_q[0];
            exp_q    <= exp_q + 12'sd1;
          end else if (!prod_q[46] && exp_q > EMIN) begin
            prod_q <= prod_q << 1;
            exp_q  <= exp_q - 12'sd1;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          if (!special_q) begin
            if (mant_sum_d[24]) begin
              mant_q <= mant_sum_d[24:1];
              exp_q  <= exp_q + 12'sd1;
            end else begin
              mant_q <= mant_sum_d[23:0];
            end
          end
          state_q <= PACK;
        end
        PACK: begin
          out_q       <= pack_d;
          ready_out_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          // ready_out is high during this state, so a strobe here is ignored.
          ready_out_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign ready_out = ready_out_q;

endmodule

// File: tb/tb_fp32_multiplier.sv
// Self-checking bench for fp32_multiplier. Expected products come from a
// real-arithmetic reference model; a compare process checks out/ready_out on
// every falling edge.
module tb_fp32_multiplier;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] a, b;
  logic        ready_in;
  logic [31:0] out;
  logic        ready_out;

  fp32_multiplier dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .ready_in  (ready_in),
    .out       (out),
    .ready_out (ready_out)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  int          acc_q[$];
  logic [31:0] held_out = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  // Exact magnitude of a finite binary32 value.
  function automatic real mag(input logic [31:0] x);
    int f = int'(x[22:0]);
    int e = int'(x[30:23]);
    if (e == 0) return $itor(f) * pow2(-149);
    return $itor(f + (1 << 23)) * pow2(e - 150);
  endfunction

  // Round a positive real to binary32 magnitude bits (RNE, with subnormals).
  function automatic logic [30:0] round_mag(input real ax);
    int  e = 0;
    real p = 1.0;
    real sc, fr;
    int  m;
    while (ax >= 2.0 * p) begin p = p * 2.0; e++; end
    while (ax < p)        begin p = p / 2.0; e--; end
    if (e < -126) e = -126;
    sc = ax / pow2(e - 23);
    m  = $rtoi(sc);
    fr = sc - $itor(m);
    if (fr > 0.5 || (fr == 0.5 && m[0])) m++;
    if (m == (1 << 24)) begin m = 1 << 23; e++; end
    if (e > 127) return {8'hFF, 23'd0};
    if (m < (1 << 23)) return {8'd0, m[22:0]};
    return {8'(e + 127), m[22:0]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    logic s    = x[31] ^ y[31];
    logic xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    logic ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    logic xinf = (x[30:0] == 31'h7F800000);
    logic yinf = (y[30:0] == 31'h7F800000);
    logic xz   = (x[30:0] == 31'd0);
    logic yz   = (y[30:0] == 31'd0);
    if (xnan || ynan) return 32'h7FC00000;
    if ((xinf && yz) || (yinf && xz)) return 32'h7FC00000;
    if (xinf || yinf) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    return {s, round_mag(mag(x) * mag(y))};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clock) begin
    logic [31:0] e;
    int          acc, lat;
    if (!reset_n) begin
      exp_q.delete();
      acc_q.delete();
      held_out = 32'd0;
    end else if (ready_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready_out: out=%08h with no operation pending", out);
      end else begin
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("result", out, e);
        lat = cyc - acc;
        n_cmp++;
        if (lat < 5 || lat > 60) begin
          n_bad++;
          $display("FAIL latency: got %0d cycles, required 5..60", lat);
        end
        held_out = e;
      end
    end else begin
      check("out_hold", out, held_out);
    end
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge while the DUT is IDLE.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    a = x; b = y; ready_in = 1'b1;
    @(posedge clock); #1;
    ready_in = 1'b0;
    exp_q.push_back(model_mul(x, y));
    acc_q.push_back(cyc);
  endtask

  // Waits for the ready_out cycle; optionally strobes ready_in during it
  // (must be ignored). Returns #1 after the edge leaving DONE.
  task automatic wait_result(input bit poke);
    int n = 0;
    while (ready_out !== 1'b1 && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no ready_out within 100 cycles");
      exp_q.delete();
      acc_q.delete();
    end else if (poke) begin
      a = $urandom; b = $urandom; ready_in = 1'b1;
    end
    @(posedge clock); #1;
    ready_in = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  localparam int NV = 22;
  logic [31:0] va [NV] = '{
    32'h3F9D70A4, 32'h44F6AF68, 32'h473FF936, 32'h7F800000, 32'hFF800000,
    32'h80000000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000, 32'h00000001,
    32'h3F800000, 32'h3F800001, 32'h3F800001, 32'h3FB504F3, 32'h00000003,
    32'h007FFFFF, 32'h00000001, 32'h00800000, 32'hFF7FFFFF, 32'h80000000,
    32'h0DA24260, 32'h3FFFFFFF
  };
  logic [31:0] vb [NV] = '{
    32'h4091EB85, 32'h4610099B, 32'hC6DDE29C, 32'h00000000, 32'h40000000,
    32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000,
    32'h3F800000, 32'h3F800001, 32'h40400000, 32'h3FB504F3, 32'h3F000000,
    32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'h7F7FFFFF, 32'h7F800000,
    32'h0DA24260, 32'h3FFFFFFF
  };

  initial begin
    reset_n = 1'b0; ready_in = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Pin the reference model against hand-computed products.
    check("model_1.23x4.56",  model_mul(32'h3F9D70A4, 32'h4091EB85), 32'h40B37B4A);
    check("model_b2b_1",      model_mul(32'h44F6AF68, 32'h4610099B), 32'h4B8ACBEC);
    check("model_b2b_2",      model_mul(32'h473FF936, 32'hC6DDE29C), 32'hCEA66413);
    check("model_inf_x_zero", model_mul(32'h7F800000, 32'h00000000), 32'h7FC00000);
    check("model_ninf_x_2",   model_mul(32'hFF800000, 32'h40000000), 32'hFF800000);
    check("model_nzero_x_1",  model_mul(32'h80000000, 32'h3F800000), 32'h80000000);
    check("model_nan_x_1",    model_mul(32'h7FC00001, 32'h3F800000), 32'h7FC00000);
    check("model_overflow",   model_mul(32'h7F7FFFFF, 32'h40000000), 32'h7F800000);
    check("model_subnormal",  model_mul(32'h00800000, 32'h3F000000), 32'h00400000);
    check("model_tie_zero",   model_mul(32'h00000001, 32'h3F000000), 32'h00000000);
    check("model_tie_even",   model_mul(32'h3F800001, 32'h40400000), 32'h40400002);
    check("model_sub_tie_up", model_mul(32'h00000003, 32'h3F000000), 32'h00000002);

    // Idle after reset: out stays zero, no ready_out.
    repeat (10) @(posedge clock);
    #1;

    // Directed vectors, back to back; every other result cycle gets an
    // ignored ready_in strobe.
    for (int i = 0; i < NV; i++) begin
      start_op(va[i], vb[i]);
      wait_result(i[0]);
    end

    // Strobe while busy with different operands: first result must return.
    start_op(32'h40490FDB, 32'h402DF854);
    repeat (3) @(posedge clock);
    #1 a = 32'h3F800000; b = 32'h3F800000; ready_in = 1'b1;
    @(posedge clock); #1 ready_in = 1'b0;
    wait_result(1'b0);

    // ready_in held for several cycles starts exactly one operation.
    a = 32'hC0A00000; b = 32'h3E800000; ready_in = 1'b1;
    @(posedge clock); #1;
    exp_q.push_back(model_mul(32'hC0A00000, 32'h3E800000));
    acc_q.push_back(cyc);
    repeat (3) @(posedge clock);
    #1 ready_in = 1'b0;
    wait_result(1'b0);
    repeat (70) @(posedge clock);
    #1;

    // Reset mid-operation: no ready_out, out cleared.
    start_op(32'h00800000, 32'h00800000);
    repeat (8) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (70) @(posedge clock);
    #1;

    // The unit works normally after an aborted operation.
    start_op(32'h40400000, 32'h40800000);
    wait_result(1'b0);
    repeat (3) @(posedge clock);
    #1;

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
